t07_ssdec_spi_rx: RTL and testbench

T07_SSDEC_SPI_RX -- requirements
Module: t07_ssdec_spi_rx

---
 rtl/t07_ssdec_pkg.sv | 22 ++
 rtl/t07_ssdec_scan.sv | 58 +++++
 rtl/t07_ssdec_spi_rx.sv | 137 +++++++++++++
 tb/tb_t07_ssdec_spi_rx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t07_ssdec_pkg.sv
// Shared constants for the SPI-fed eight-digit seven-segment display receiver.
// The hex font table is only used when T07_SSDEC_HEXDECODE_EN is defined.
package t07_ssdec_pkg;

    localparam int FRAME_W    = 16;
    localparam int NUM_DIGITS = 8;
    localparam int BITCNT_SAT = FRAME_W + 1;

    localparam logic [7:0] ADDR_DIGIT_MAX = 8'h07;
    localparam logic [7:0] ADDR_CTRL      = 8'h0F;
    localparam logic [7:0] CTRL_RESET     = 8'h01;

    localparam int CTRL_DISP_EN  = 0;
    localparam int CTRL_HEX_MODE = 1;

    // Segment order {g,f,e,d,c,b,a}; element 0 is the glyph for nibble 0.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/t07_ssdec_scan.sv
// Digit scan: prescaler, scan index and registered anode/segment outputs.
// Font decoding is present only with T07_SSDEC_HEXDECODE_EN defined.
module t07_ssdec_scan
    import t07_ssdec_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  display_on,
`ifdef T07_SSDEC_HEXDECODE_EN
    input  logic                  hex_mode,
`endif
    input  logic [NUM_DIGITS-1:0][7:0] digits,
    output logic [7:0]            digit_an,
    output logic [7:0]            digit_seg
);

    logic [15:0] presc;
    logic [2:0]  idx;
    logic [7:0]  seg_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == 16'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 3'd1;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    always_comb begin
        seg_next = digits[idx];
`ifdef T07_SSDEC_HEXDECODE_EN
        if (hex_mode) begin
            seg_next = {digits[idx][7], HEX_FONT[digits[idx][3:0]]};
        end
`endif
    end

    // Outputs follow the index by one cycle; blanking never stops the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_an  <= '0;
            digit_seg <= '0;
        end else if (display_on) begin
            digit_an  <= 8'd1 << idx;
            digit_seg <= seg_next;
        end else begin
            digit_an  <= '0;
            digit_seg <= '0;
        end
    end

endmodule

// File: rtl/t07_ssdec_spi_rx.sv
// SPI-mode-0 receiver writing eight digit registers and a control register,
// driving a scanned display. Optional font decode: T07_SSDEC_HEXDECODE_EN.
module t07_ssdec_spi_rx
    import t07_ssdec_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ssdec_sck,
    input  logic       ssdec_sdi,
    input  logic       ssdec_ss,
    output logic [7:0] digit_seg,
    output logic [7:0] digit_an,
    output logic       frame_valid,
    output logic       frame_err
);

    logic [1:0] sck_sync, sdi_sync, ss_sync;
    logic       sck_prev, ss_prev;
    logic       sck_s, sdi_s, ss_s;
    logic       sck_rise, ss_fall, ss_rise;

    logic [FRAME_W-1:0] shift_reg;
    logic [4:0]         bit_cnt;
    logic               frame_active;

    logic [NUM_DIGITS-1:0][7:0] digits;
    logic [7:0]                 ctrl;

    logic [7:0] addr, data;
    logic       addr_digit, addr_ctrl, commit, reject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= 2'b00;
            sdi_sync <= 2'b00;
            ss_sync  <= 2'b11;
            sck_prev <= 1'b0;
            ss_prev  <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[0], ssdec_sck};
            sdi_sync <= {sdi_sync[0], ssdec_sdi};
            ss_sync  <= {ss_sync[0], ssdec_ss};
            sck_prev <= sck_sync[1];
            ss_prev  <= ss_sync[1];
        end
    end

    assign sck_s    = sck_sync[1];
    assign sdi_s    = sdi_sync[1];
    assign ss_s     = ss_sync[1];
    assign sck_rise = sck_s & ~sck_prev;
    assign ss_fall  = ~ss_s & ss_prev;
    assign ss_rise  = ss_s & ~ss_prev;

    assign addr       = shift_reg[15:8];
    assign data       = shift_reg[7:0];
    assign addr_digit = (addr <= ADDR_DIGIT_MAX);
    assign addr_ctrl  = (addr == ADDR_CTRL);

    // Only frames opened by an ss fall seen while enabled can end in commit or error.
    assign commit = en & frame_active & ss_rise & (bit_cnt == 5'(FRAME_W))
                  & (addr_digit | addr_ctrl);
    assign reject = en & frame_active & ss_rise & ~commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            frame_active <= 1'b0;
        end else if (!en) begin
            bit_cnt      <= '0;
            frame_active <= 1'b0;
        end else begin
            if (ss_fall) begin
                bit_cnt      <= '0;
                frame_active <= 1'b1;
            end else if (!ss_s && sck_rise) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], sdi_s};
                if (bit_cnt != 5'(BITCNT_SAT)) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (ss_rise) begin
                frame_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
            ctrl   <= CTRL_RESET;
        end else if (commit) begin
            if (addr_digit) begin
                digits[addr[2:0]] <= data;
            end else begin
                ctrl <= data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= commit;
            frame_err   <= reject;
        end
    end

`ifdef T07_SSDEC_HEXDECODE_EN
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^ctrl[7:2];
`else
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^ctrl[7:1];
`endif

    t07_ssdec_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .display_on (ctrl[CTRL_DISP_EN] & en),
`ifdef T07_SSDEC_HEXDECODE_EN
        .hex_mode   (ctrl[CTRL_HEX_MODE]),
`endif
        .digits     (digits),
        .digit_an   (digit_an),
        .digit_seg  (digit_seg)
    );

endmodule

// File: tb/tb_t07_ssdec_spi_rx.sv
// Directed self-checking bench for t07_ssdec_spi_rx with SCAN_DIV=4.
// The font test runs only when T07_SSDEC_HEXDECODE_EN is defined.
module tb_t07_ssdec_spi_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       ssdec_sck = 1'b0;
    logic       ssdec_sdi = 1'b0;
    logic       ssdec_ss = 1'b1;
    logic [7:0] digit_seg;
    logic [7:0] digit_an;
    logic       frame_valid;
    logic       frame_err;

    int total_checks  = 0;
    int passed_checks = 0;
    int valid_cnt     = 0;
    int err_cnt       = 0;

    t07_ssdec_spi_rx #(
        .SCAN_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ssdec_sck   (ssdec_sck),
        .ssdec_sdi   (ssdec_sdi),
        .ssdec_ss    (ssdec_ss),
        .digit_seg   (digit_seg),
        .digit_an    (digit_an),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1)   err_cnt++;
    end

    task automatic clear_counts();
        @(negedge clk);
        valid_cnt = 0;
        err_cnt   = 0;
    endtask

    task automatic ss_low();
        ssdec_ss = 1'b0;
        #40;
    endtask

    task automatic ss_high();
        ssdec_ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Bits beyond the 16-bit word are sent as zeros.
    task automatic send_bits(input logic [15:0] word, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            ssdec_sdi = (i < 16) ? word[15 - i] : 1'b0;
            #40;
            ssdec_sck = 1'b1;
            #40;
            ssdec_sck = 1'b0;
        end
        #40;
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits);
        ss_low();
        send_bits(word, 0, nbits);
        ss_high();
    endtask

    task automatic wait_an(input logic [7:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (digit_an === target) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_checks++;
        if (digit_an !== 8'h00) $display("[TB] FAIL reset_an: got %h expected 00", digit_an);
        else passed_checks++;
        total_checks++;
        if (digit_seg !== 8'h00) $display("[TB] FAIL reset_seg: got %h expected 00", digit_seg);
        else passed_checks++;
        total_checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0)
            $display("[TB] FAIL reset_pulses: got valid=%b err=%b expected 0 0", frame_valid, frame_err);
        else passed_checks++;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total_checks++;
        if (digit_an !== 8'h01) $display("[TB] FAIL reset_release_an: got %h expected 01", digit_an);
        else passed_checks++;
        total_checks++;
        if (digit_seg !== 8'h00) $display("[TB] FAIL reset_release_seg: got %h expected 00", digit_seg);
        else passed_checks++;
    endtask

    task automatic test_commit();
        bit found;
        clear_counts();
        spi_frame(16'h035B, 16);
        total_checks++;
        if (valid_cnt !== 1 || err_cnt !== 0)
            $display("[TB] FAIL commit_pulses: got valid=%0d err=%0d expected 1 0", valid_cnt, err_cnt);
        else passed_checks++;
        wait_an(8'h08, found);
        total_checks++;
        if (!found || digit_seg !== 8'h5B)
            $display("[TB] FAIL commit_digit3: got an_found=%b seg=%h expected 1 5b", found, digit_seg);
        else passed_checks++;
        wait_an(8'h01, found);
        total_checks++;
        if (!found || digit_seg !== 8'h00)
            $display("[TB] FAIL commit_digit0: got an_found=%b seg=%h expected 1 00", found, digit_seg);
        else passed_checks++;
    endtask

    task automatic test_bad_length();
        bit found;
        clear_counts();
        spi_frame(16'h0377, 15);
        spi_frame(16'h0366, 17);
        total_checks++;
        if (err_cnt !== 2 || valid_cnt !== 0)
            $display("[TB] FAIL bad_length_pulses: got err=%0d valid=%0d expected 2 0", err_cnt, valid_cnt);
        else passed_checks++;
        wait_an(8'h08, found);
        total_checks++;
        if (!found || digit_seg !== 8'h5B)
            $display("[TB] FAIL bad_length_digit3: got an_found=%b seg=%h expected 1 5b", found, digit_seg);
        else passed_checks++;
    endtask

    task automatic test_bad_addr();
        bit found;
        clear_counts();
        spi_frame(16'h09AA, 16);
        total_checks++;
        if (err_cnt !== 1 || valid_cnt !== 0)
            $display("[TB] FAIL bad_addr_pulses: got err=%0d valid=%0d expected 1 0", err_cnt, valid_cnt);
        else passed_checks++;
        wait_an(8'h02, found);
        total_checks++;
        if (!found || digit_seg !== 8'h00)
            $display("[TB] FAIL bad_addr_digit1: got an_found=%b seg=%h expected 1 00", found, digit_seg);
        else passed_checks++;
    endtask

    task automatic test_display_off();
        bit found;
        bit lit;
        clear_counts();
        spi_frame(16'h0F00, 16);
        lit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digit_an !== 8'h00 || digit_seg !== 8'h00) lit = 1'b1;
        end
        total_checks++;
        if (lit) $display("[TB] FAIL display_off_blank: got lit=1 expected lit=0 (an=%h seg=%h)", digit_an, digit_seg);
        else passed_checks++;
        spi_frame(16'h0F01, 16);
        total_checks++;
        if (valid_cnt !== 2 || err_cnt !== 0)
            $display("[TB] FAIL display_ctrl_pulses: got valid=%0d err=%0d expected 2 0", valid_cnt, err_cnt);
        else passed_checks++;
        wait_an(8'h08, found);
        total_checks++;
        if (!found || digit_seg !== 8'h5B)
            $display("[TB] FAIL display_resume: got an_found=%b seg=%h expected 1 5b", found, digit_seg);
        else passed_checks++;
    endtask

    task automatic test_reset_abort();
        bit found;
        clear_counts();
        ss_low();
        send_bits(16'h02FF, 0, 8);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_checks++;
        if (digit_an !== 8'h00 || digit_seg !== 8'h00)
            $display("[TB] FAIL abort_in_reset: got an=%h seg=%h expected 00 00", digit_an, digit_seg);
        else passed_checks++;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total_checks++;
        if (digit_an !== 8'h01) $display("[TB] FAIL abort_release_an: got %h expected 01", digit_an);
        else passed_checks++;
        send_bits(16'h02FF, 8, 8);
        ss_high();
        total_checks++;
        if (valid_cnt !== 0) $display("[TB] FAIL abort_no_commit: got valid=%0d expected 0", valid_cnt);
        else passed_checks++;
        wait_an(8'h04, found);
        total_checks++;
        if (!found || digit_seg !== 8'h00)
            $display("[TB] FAIL abort_digit2: got an_found=%b seg=%h expected 1 00", found, digit_seg);
        else passed_checks++;
    endtask

    task automatic test_enable_low();
        bit found;
        clear_counts();
        ss_low();
        send_bits(16'h0411, 0, 8);
        en = 1'b0;
        repeat (4) @(negedge clk);
        total_checks++;
        if (digit_an !== 8'h00 || digit_seg !== 8'h00)
            $display("[TB] FAIL en_low_blank: got an=%h seg=%h expected 00 00", digit_an, digit_seg);
        else passed_checks++;
        send_bits(16'h0411, 8, 8);
        ss_high();
        spi_frame(16'h0433, 16);
        total_checks++;
        if (valid_cnt !== 0 || err_cnt !== 0)
            $display("[TB] FAIL en_low_pulses: got valid=%0d err=%0d expected 0 0", valid_cnt, err_cnt);
        else passed_checks++;
        en = 1'b1;
        wait_an(8'h10, found);
        total_checks++;
        if (!found || digit_seg !== 8'h00)
            $display("[TB] FAIL en_low_digit4: got an_found=%b seg=%h expected 1 00", found, digit_seg);
        else passed_checks++;
    endtask

    task automatic test_back_to_back();
        bit found;
        clear_counts();
        spi_frame(16'h0511, 16);
        spi_frame(16'h0622, 16);
        spi_frame(16'h07C3, 16);
        total_checks++;
        if (valid_cnt !== 3 || err_cnt !== 0)
            $display("[TB] FAIL b2b_pulses: got valid=%0d err=%0d expected 3 0", valid_cnt, err_cnt);
        else passed_checks++;
        wait_an(8'h20, found);
        total_checks++;
        if (!found || digit_seg !== 8'h11)
            $display("[TB] FAIL b2b_digit5: got an_found=%b seg=%h expected 1 11", found, digit_seg);
        else passed_checks++;
        wait_an(8'h40, found);
        total_checks++;
        if (!found || digit_seg !== 8'h22)
            $display("[TB] FAIL b2b_digit6: got an_found=%b seg=%h expected 1 22", found, digit_seg);
        else passed_checks++;
        wait_an(8'h80, found);
        total_checks++;
        if (!found || digit_seg !== 8'hC3)
            $display("[TB] FAIL b2b_digit7: got an_found=%b seg=%h expected 1 c3", found, digit_seg);
        else passed_checks++;
    endtask

`ifdef T07_SSDEC_HEXDECODE_EN
    task automatic test_hex_decode();
        bit found;
        spi_frame(16'h0F03, 16);
        spi_frame(16'h0087, 16);
        wait_an(8'h01, found);
        total_checks++;
        if (!found || digit_seg !== 8'h87)
            $display("[TB] FAIL hex_digit0: got an_found=%b seg=%h expected 1 87", found, digit_seg);
        else passed_checks++;
        wait_an(8'h20, found);
        total_checks++;
        if (!found || digit_seg !== 8'h06)
            $display("[TB] FAIL hex_digit5: got an_found=%b seg=%h expected 1 06", found, digit_seg);
        else passed_checks++;
        spi_frame(16'h0F01, 16);
        wait_an(8'h01, found);
        total_checks++;
        if (!found || digit_seg !== 8'h87)
            $display("[TB] FAIL hex_raw_digit0: got an_found=%b seg=%h expected 1 87", found, digit_seg);
        else passed_checks++;
    endtask
`endif

    initial begin
        $display("[TB] starting t07_ssdec_spi_rx bench");
        test_reset();
        test_commit();
        test_bad_length();
        test_bad_addr();
        test_display_off();
        test_reset_abort();
        test_enable_low();
        test_back_to_back();
`ifdef T07_SSDEC_HEXDECODE_EN
        test_hex_decode();
`endif
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
